// File: rtl/cascade_match_counter.sv
// Cascaded multi-digit up/down counter with saturate/wrap, load/clear,
// terminal-count output and a masked compare driving Z and a sticky flag.
module cascade_match_counter #(
    parameter int DIGIT_W   = 4,
    parameter int DIGITS    = 4,
    parameter int DIGIT_MAX = 15
) (
    input  logic                        CK,
    input  logic                        RN,
    input  logic                        EN,
    input  logic                        DIR,
    input  logic                        SAT,
    input  logic                        CLR,
    input  logic                        LOAD,
    input  logic [DIGIT_W*DIGITS-1:0]   LOAD_VAL,
    input  logic [DIGIT_W*DIGITS-1:0]   CMP_VAL,
    input  logic [DIGIT_W*DIGITS-1:0]   CMP_MASK,
    input  logic                        STKY_CLR,
    output logic [DIGIT_W*DIGITS-1:0]   COUNT,
    output logic                        TC,
    output logic                        Z,
    output logic                        STKY
);

    localparam int N = DIGIT_W * DIGITS;
    localparam logic [DIGIT_W-1:0] DMAX = DIGIT_W'(DIGIT_MAX);
    localparam logic [DIGIT_W-1:0] ONE  = DIGIT_W'(1);

    logic [N-1:0]       stepped;
    logic [N-1:0]       clamped;
    logic [DIGIT_W-1:0] digit;
    logic [DIGIT_W-1:0] lv_digit;
    logic               carry;
    logic               all_max;
    logic               all_zero;
    logic               terminal;
    logic               match;

    // Carry/borrow ripples digit by digit within the cycle.
    always_comb begin
        stepped  = COUNT;
        clamped  = '0;
        digit    = '0;
        lv_digit = '0;
        carry    = EN;
        all_max  = 1'b1;
        all_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            digit = COUNT[i*DIGIT_W +: DIGIT_W];
            if (digit != DMAX) all_max = 1'b0;
            if (digit != '0)   all_zero = 1'b0;
            if (carry) begin
                if (!DIR) begin
                    if (digit == DMAX) begin
                        stepped[i*DIGIT_W +: DIGIT_W] = '0;
                    end else begin
                        stepped[i*DIGIT_W +: DIGIT_W] = digit + ONE;
                        carry = 1'b0;
                    end
                end else begin
                    if (digit == '0) begin
                        stepped[i*DIGIT_W +: DIGIT_W] = DMAX;
                    end else begin
                        stepped[i*DIGIT_W +: DIGIT_W] = digit - ONE;
                        carry = 1'b0;
                    end
                end
            end
            lv_digit = LOAD_VAL[i*DIGIT_W +: DIGIT_W];
            clamped[i*DIGIT_W +: DIGIT_W] = (lv_digit > DMAX) ? DMAX : lv_digit;
        end
    end

    assign terminal = DIR ? all_zero : all_max;
    assign TC       = EN & terminal & ~CLR & ~LOAD;
    assign match    = (CMP_MASK != '0) &&
                      ((COUNT & CMP_MASK) == (CMP_VAL & CMP_MASK));

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            COUNT <= '0;
        end else if (CLR) begin
            COUNT <= '0;
        end else if (LOAD) begin
            COUNT <= clamped;
        end else if (EN) begin
            if (!(terminal && SAT)) COUNT <= stepped;
        end
    end

    // Set beats clear when both land on the same edge.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            Z    <= 1'b0;
            STKY <= 1'b0;
        end else begin
            Z <= match;
            if (match)         STKY <= 1'b1;
            else if (STKY_CLR) STKY <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cascade_match_counter.sv
// Directed bench for cascade_match_counter: hex instance driven from a vector
// table, a BCD instance for clamping/BCD carries, plus match/sticky sequences.
module tb_cascade_match_counter;

    logic        CK = 1'b0;
    logic        RN = 1'b0;
    logic        EN = 1'b0;
    logic        DIR = 1'b0;
    logic        SAT = 1'b0;
    logic        CLR = 1'b0;
    logic        LOAD = 1'b0;
    logic [15:0] LOAD_VAL = '0;
    logic [15:0] CMP_VAL = '0;
    logic [15:0] CMP_MASK = '0;
    logic        STKY_CLR = 1'b0;

    logic [15:0] hex_count, bcd_count;
    logic        hex_tc, bcd_tc, hex_z, bcd_z, hex_stky, bcd_stky;

    int checks = 0;
    int failures = 0;

    always #5 CK = ~CK;

    cascade_match_counter #(.DIGIT_W(4), .DIGITS(4), .DIGIT_MAX(15)) dut_hex (
        .CK(CK), .RN(RN), .EN(EN), .DIR(DIR), .SAT(SAT), .CLR(CLR),
        .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .CMP_VAL(CMP_VAL),
        .CMP_MASK(CMP_MASK), .STKY_CLR(STKY_CLR),
        .COUNT(hex_count), .TC(hex_tc), .Z(hex_z), .STKY(hex_stky)
    );

    cascade_match_counter #(.DIGIT_W(4), .DIGITS(4), .DIGIT_MAX(9)) dut_bcd (
        .CK(CK), .RN(RN), .EN(EN), .DIR(DIR), .SAT(SAT), .CLR(CLR),
        .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .CMP_VAL(CMP_VAL),
        .CMP_MASK(CMP_MASK), .STKY_CLR(STKY_CLR),
        .COUNT(bcd_count), .TC(bcd_tc), .Z(bcd_z), .STKY(bcd_stky)
    );

    typedef struct {
        logic        clr;
        logic        load;
        logic        en;
        logic        dir;
        logic        sat;
        logic [15:0] val;
        logic        tc;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic clr, logic load, logic en, logic dir,
                                logic sat, logic [15:0] val, logic tc,
                                logic [15:0] cnt);
        vec_t v;
        v.clr = clr; v.load = load; v.en = en; v.dir = dir; v.sat = sat;
        v.val = val; v.tc = tc; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic clr, logic load, logic en, logic dir,
                         logic sat, logic [15:0] val);
        CLR = clr; LOAD = load; EN = en; DIR = dir; SAT = sat; LOAD_VAL = val;
    endtask

    task automatic edge_step();
        @(posedge CK);
        #1;
    endtask

    logic [15:0] model_cnt, prev_cnt;
    logic        model_z, model_stky;

    initial begin
        // clr load en dir sat val -> tc before edge, count after edge
        vecs.push_back(mk(0, 1, 1, 0, 0, 16'h1234, 0, 16'h1234));
        vecs.push_back(mk(1, 1, 1, 0, 0, 16'h9999, 0, 16'h0000));
        vecs.push_back(mk(0, 1, 1, 0, 0, 16'h0050, 0, 16'h0050));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 0, 16'h0051));
        vecs.push_back(mk(0, 0, 1, 1, 0, 16'h0000, 0, 16'h0050));
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'hFFFE, 0, 16'hFFFE));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 0, 16'hFFFF));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 1, 16'h0000));
        vecs.push_back(mk(0, 0, 1, 1, 0, 16'h0000, 1, 16'hFFFF));
        vecs.push_back(mk(0, 0, 1, 1, 1, 16'h0000, 0, 16'hFFFE));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0000, 0, 16'hFFFF));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0000, 1, 16'hFFFF));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0000, 1, 16'hFFFF));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 0, 16'hFFFF));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 1, 16'h0000));
        vecs.push_back(mk(0, 0, 1, 1, 1, 16'h0000, 1, 16'h0000));
        vecs.push_back(mk(0, 0, 1, 1, 0, 16'h0000, 1, 16'hFFFF));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 1, 16'h0000));
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0FFF, 0, 16'h0FFF));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 0, 16'h1000));
        vecs.push_back(mk(0, 0, 1, 1, 0, 16'h0000, 0, 16'h0FFF));

        // Reset state, then an asynchronous reset mid-count.
        #2;
        check("reset_count", 32'(hex_count), 32'h0);
        check("reset_z", 32'(hex_z), 32'h0);
        check("reset_stky", 32'(hex_stky), 32'h0);
        check("reset_tc", 32'(hex_tc), 32'h0);
        @(negedge CK);
        RN = 1'b1;
        EN = 1'b1;
        repeat (5) edge_step();
        check("pre_reset_count", 32'(hex_count), 32'h5);
        #2 RN = 1'b0;
        #1;
        check("async_reset_count", 32'(hex_count), 32'h0);
        @(negedge CK);
        RN = 1'b1;
        repeat (20) edge_step();
        check("count20_hex", 32'(hex_count), 32'h0014);
        check("count20_bcd", 32'(bcd_count), 32'h0020);
        check("count20_z", 32'(hex_z), 32'h0);
        check("count20_stky", 32'(hex_stky), 32'h0);

        // Table-driven priority, wrap, saturate and direction changes.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].dir,
                  vecs[i].sat, vecs[i].val);
            #1;
            check($sformatf("vec%0d_tc", i), 32'(hex_tc), 32'(vecs[i].tc));
            edge_step();
            check($sformatf("vec%0d_count", i), 32'(hex_count),
                  32'(vecs[i].cnt));
        end

        // BCD instance: ripple, borrow wrap with TC, load clamping.
        drive(0, 1, 0, 0, 0, 16'h0999); edge_step();
        check("bcd_load_0999", 32'(bcd_count), 32'h0999);
        drive(0, 0, 1, 0, 0, 16'h0000); edge_step();
        check("bcd_up_1000", 32'(bcd_count), 32'h1000);
        drive(0, 1, 0, 0, 0, 16'h0000); edge_step();
        drive(0, 0, 1, 1, 0, 16'h0000); #1;
        check("bcd_down_tc", 32'(bcd_tc), 32'h1);
        edge_step();
        check("bcd_down_9999", 32'(bcd_count), 32'h9999);
        drive(0, 1, 0, 0, 0, 16'h00FA); edge_step();
        check("bcd_clamp_00fa", 32'(bcd_count), 32'h0099);
        check("hex_noclamp_00fa", 32'(hex_count), 32'h00FA);
        drive(0, 1, 0, 0, 0, 16'hFFFE); edge_step();
        check("bcd_clamp_fffe", 32'(bcd_count), 32'h9999);

        // Masked match while counting up from 0x0100.
        CMP_MASK = 16'h00FF;
        CMP_VAL  = 16'hAB07;
        drive(0, 1, 0, 0, 0, 16'h0100); edge_step();
        model_cnt  = 16'h0100;
        model_stky = 1'b0;
        drive(0, 0, 1, 0, 0, 16'h0000);
        for (int k = 0; k < 270; k++) begin
            prev_cnt  = model_cnt;
            model_cnt = model_cnt + 16'h1;
            model_z   = (prev_cnt[7:0] == 8'h07);
            if (model_z) model_stky = 1'b1;
            edge_step();
            check($sformatf("match_count_%0d", k), 32'(hex_count),
                  32'(model_cnt));
            check($sformatf("match_z_%0d", k), 32'(hex_z), 32'(model_z));
            check($sformatf("match_stky_%0d", k), 32'(hex_stky),
                  32'(model_stky));
        end

        // Holding on a matching value keeps Z high; set beats clear.
        drive(0, 1, 0, 0, 0, 16'h0007); edge_step();
        drive(0, 0, 0, 0, 0, 16'h0000); STKY_CLR = 1'b1; edge_step();
        check("hold_match_z", 32'(hex_z), 32'h1);
        check("stky_set_wins", 32'(hex_stky), 32'h1);
        STKY_CLR = 1'b0;
        drive(0, 1, 0, 0, 0, 16'h0010); edge_step();
        check("leave_match_z", 32'(hex_z), 32'h1);
        drive(0, 0, 0, 0, 0, 16'h0000); STKY_CLR = 1'b1; edge_step();
        check("stky_cleared", 32'(hex_stky), 32'h0);
        check("nomatch_z", 32'(hex_z), 32'h0);
        STKY_CLR = 1'b0;

        // An all-zero mask disables matching even where values agree.
        CMP_MASK = 16'h0000;
        CMP_VAL  = 16'h0000;
        drive(0, 1, 0, 0, 0, 16'h0000); edge_step();
        edge_step();
        edge_step();
        check("mask0_z", 32'(hex_z), 32'h0);
        check("mask0_stky", 32'(hex_stky), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
